mem_access_unit: RTL and testbench

Load/store sequencer that sits directly upstream of the data-memory bus in the memory stage. It accepts one load or store per handshake from execute and decodes the RISC-V funct3. It drives byte/half/word requests onto the bus, splitting misaligned accesses into byte beats when enabled. It then assembles and extends load data and returns one completion pulse with data or a fault to writeback.

---
 rtl/mem_access_unit.sv | 211 +++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store sequencer between execute and the data-memory bus: decodes funct3,
// splits misaligned accesses into byte beats and sign/zero-extends load data.
`ifndef MEM_ACCESS_UNIT_DEFS
`define MEM_ACCESS_UNIT_DEFS
`define ADDR_W 32
`define WORD_W 32
`define MEM_COUNT_W 2
`define MEM_COUNT_NONE 2'd0
`define MEM_COUNT_BYTE 2'd1
`define MEM_COUNT_HALF 2'd2
`define MEM_COUNT_WORD 2'd3
`define MEM_CODE_W 2
`define MEM_CODE_OK 2'd0
`define MEM_CODE_OUT_OF_BOUNDS 2'd1
`endif

module mem_access_unit #(
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic                    clk,
  input  logic                    aresetn,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic                    i_is_store,
  input  logic [2:0]              i_funct3,
  input  logic [`ADDR_W-1:0]      i_addr,
  input  logic [`WORD_W-1:0]      i_wr_data,
  output logic [`ADDR_W-1:0]      o_mem_req_addr,
  output logic [`WORD_W-1:0]      o_mem_req_wr_data,
  output logic                    o_mem_req_wr_en,
  output logic [`MEM_COUNT_W-1:0] o_mem_req_count,
  input  logic [`WORD_W-1:0]      i_mem_res_data,
  input  logic [`MEM_CODE_W-1:0]  i_mem_res_code,
  output logic                    o_done,
  output logic [`WORD_W-1:0]      o_rd_data,
  output logic                    o_fault
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e                  state_q, state_d;
  logic                    is_store_q, is_store_d;
  logic [2:0]              funct3_q, funct3_d;
  logic [`ADDR_W-1:0]      base_q, base_d;
  logic [`WORD_W-1:0]      wdata_q, wdata_d;
  logic                    split_q, split_d;
  logic [1:0]              beat_q, beat_d;
  logic [1:0]              last_q, last_d;
  logic [`MEM_COUNT_W-1:0] count_q, count_d;
  logic [`WORD_W-1:0]      asm_q, asm_d;
  logic [`WORD_W-1:0]      rd_q, rd_d;
  logic                    fault_q, fault_d;
  logic [`ADDR_W-1:0]      req_addr_q, req_addr_d;
  logic [`WORD_W-1:0]      req_data_q, req_data_d;

  logic                    op_ok;
  logic                    misaligned;
  logic [`MEM_COUNT_W-1:0] size_cnt;
  logic [`WORD_W-1:0]      sized_wdata;
  logic [1:0]              beat_nx;
  logic [`WORD_W-1:0]      asm_nx;
  logic [`WORD_W-1:0]      ext;

  // Decode of the request currently offered by execute.
  always_comb begin
    op_ok       = 1'b0;
    size_cnt    = `MEM_COUNT_WORD;
    sized_wdata = i_wr_data;
    case (i_funct3)
      3'b000, 3'b001, 3'b010: op_ok = 1'b1;
      3'b100, 3'b101:         op_ok = !i_is_store;
      default:                op_ok = 1'b0;
    endcase
    misaligned = ((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
                 ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
    case (i_funct3[1:0])
      2'b00: begin
        size_cnt    = `MEM_COUNT_BYTE;
        sized_wdata = {{(`WORD_W-8){1'b0}}, i_wr_data[7:0]};
      end
      2'b01: begin
        size_cnt    = `MEM_COUNT_HALF;
        sized_wdata = {{(`WORD_W-16){1'b0}}, i_wr_data[15:0]};
      end
      default: begin
        size_cnt    = `MEM_COUNT_WORD;
        sized_wdata = i_wr_data;
      end
    endcase
  end

  // Split beats deposit one byte at lane beat_q; aligned beats take the whole response.
  always_comb begin
    beat_nx = beat_q + 2'd1;
    asm_nx  = split_q ? (asm_q | ({{(`WORD_W-8){1'b0}}, i_mem_res_data[7:0]} << {beat_q, 3'b000}))
                      : i_mem_res_data;
    case (funct3_q)
      3'b000:  ext = {{(`WORD_W-8){asm_nx[7]}}, asm_nx[7:0]};
      3'b001:  ext = {{(`WORD_W-16){asm_nx[15]}}, asm_nx[15:0]};
      3'b100:  ext = {{(`WORD_W-8){1'b0}}, asm_nx[7:0]};
      3'b101:  ext = {{(`WORD_W-16){1'b0}}, asm_nx[15:0]};
      default: ext = asm_nx;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    funct3_d   = funct3_q;
    base_d     = base_q;
    wdata_d    = wdata_q;
    split_d    = split_q;
    beat_d     = beat_q;
    last_d     = last_q;
    count_d    = count_q;
    asm_d      = asm_q;
    rd_d       = rd_q;
    fault_d    = fault_q;
    req_addr_d = req_addr_q;
    req_data_d = req_data_q;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          is_store_d = i_is_store;
          funct3_d   = i_funct3;
          base_d     = i_addr;
          wdata_d    = i_wr_data;
          asm_d      = '0;
          beat_d     = 2'd0;
          if (!op_ok || (misaligned && !SPLIT_MISALIGNED)) begin
            fault_d = 1'b1;
            rd_d    = '0;
            state_d = DONE;
          end else begin
            split_d    = misaligned;
            last_d     = !misaligned ? 2'd0 : ((i_funct3[1:0] == 2'b01) ? 2'd1 : 2'd3);
            count_d    = misaligned ? `MEM_COUNT_BYTE : size_cnt;
            req_addr_d = i_addr;
            req_data_d = misaligned ? {{(`WORD_W-8){1'b0}}, i_wr_data[7:0]} : sized_wdata;
            state_d    = REQ;
          end
        end
      end
      REQ: state_d = WAIT;
      WAIT: begin
        if (i_mem_res_code == `MEM_CODE_OUT_OF_BOUNDS) begin
          fault_d = 1'b1;
          rd_d    = '0;
          state_d = DONE;
        end else begin
          asm_d = asm_nx;
          if (beat_q != last_q) begin
            beat_d     = beat_nx;
            req_addr_d = base_q + `ADDR_W'(beat_nx);
            req_data_d = {{(`WORD_W-8){1'b0}}, wdata_q[{beat_nx, 3'b000} +: 8]};
            state_d    = REQ;
          end else begin
            fault_d = 1'b0;
            rd_d    = is_store_q ? '0 : ext;
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      is_store_q <= 1'b0;
      funct3_q   <= 3'd0;
      base_q     <= '0;
      wdata_q    <= '0;
      split_q    <= 1'b0;
      beat_q     <= 2'd0;
      last_q     <= 2'd0;
      count_q    <= `MEM_COUNT_NONE;
      asm_q      <= '0;
      rd_q       <= '0;
      fault_q    <= 1'b0;
      req_addr_q <= '0;
      req_data_q <= '0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      funct3_q   <= funct3_d;
      base_q     <= base_d;
      wdata_q    <= wdata_d;
      split_q    <= split_d;
      beat_q     <= beat_d;
      last_q     <= last_d;
      count_q    <= count_d;
      asm_q      <= asm_d;
      rd_q       <= rd_d;
      fault_q    <= fault_d;
      req_addr_q <= req_addr_d;
      req_data_q <= req_data_d;
    end
  end

  assign o_ready           = (state_q == IDLE);
  assign o_done            = (state_q == DONE);
  assign o_fault           = fault_q;
  assign o_rd_data         = rd_q;
  assign o_mem_req_addr    = req_addr_q;
  assign o_mem_req_wr_data = req_data_q;
  assign o_mem_req_count   = (state_q == REQ) ? count_q : `MEM_COUNT_NONE;
  assign o_mem_req_wr_en   = (state_q == REQ) && is_store_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit: a 256-byte bus memory answers requests and
// a byte-level reference model predicts beats, latency, data and faults.
`ifndef MEM_ACCESS_UNIT_DEFS
`define MEM_ACCESS_UNIT_DEFS
`define ADDR_W 32
`define WORD_W 32
`define MEM_COUNT_W 2
`define MEM_COUNT_NONE 2'd0
`define MEM_COUNT_BYTE 2'd1
`define MEM_COUNT_HALF 2'd2
`define MEM_COUNT_WORD 2'd3
`define MEM_CODE_W 2
`define MEM_CODE_OK 2'd0
`define MEM_CODE_OUT_OF_BOUNDS 2'd1
`endif

module tb_mem_access_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        aresetn;
  logic        valid1, valid0, isStore;
  logic [2:0]  funct3;
  logic [31:0] addr, wrData;
  logic        ready1, ready0, we1, we0, done1, done0, fault1, fault0;
  logic [31:0] reqAddr1, reqData1, reqAddr0, reqData0, rd1, rd0;
  logic [1:0]  cnt1, cnt0;
  logic [31:0] resData1;
  logic [1:0]  resCode1;
  logic [31:0] resData0 = 32'hCAFE_8001;
  logic [1:0]  resCode0 = `MEM_CODE_OK;

  int errors = 0;
  int checks = 0;
  int dut0Reqs = 0;
  logic [31:0] obsRd;
  logic        obsFault;

  logic [7:0]  busMem [256];
  logic [7:0]  refMem [256];
  logic [31:0] seenAddr [$];
  logic [31:0] seenData [$];
  logic [1:0]  seenCnt  [$];
  logic        seenWe   [$];
  int          busN;
  logic [31:0] busRd;

  mem_access_unit #(.SPLIT_MISALIGNED(1'b1)) dut1 (
    .clk(clk), .aresetn(aresetn), .i_valid(valid1), .o_ready(ready1),
    .i_is_store(isStore), .i_funct3(funct3), .i_addr(addr), .i_wr_data(wrData),
    .o_mem_req_addr(reqAddr1), .o_mem_req_wr_data(reqData1), .o_mem_req_wr_en(we1),
    .o_mem_req_count(cnt1), .i_mem_res_data(resData1), .i_mem_res_code(resCode1),
    .o_done(done1), .o_rd_data(rd1), .o_fault(fault1));

  mem_access_unit #(.SPLIT_MISALIGNED(1'b0)) dut0 (
    .clk(clk), .aresetn(aresetn), .i_valid(valid0), .o_ready(ready0),
    .i_is_store(isStore), .i_funct3(funct3), .i_addr(addr), .i_wr_data(wrData),
    .o_mem_req_addr(reqAddr0), .o_mem_req_wr_data(reqData0), .o_mem_req_wr_en(we0),
    .o_mem_req_count(cnt0), .i_mem_res_data(resData0), .i_mem_res_code(resCode0),
    .o_done(done0), .o_rd_data(rd0), .o_fault(fault0));

  // Bus memory: anything touching bytes at or above 0x100 is rejected.
  always @(posedge clk) begin
    if (cnt1 != `MEM_COUNT_NONE) begin
      busN = (cnt1 == `MEM_COUNT_BYTE) ? 1 : (cnt1 == `MEM_COUNT_HALF) ? 2 : 4;
      seenAddr.push_back(reqAddr1);
      seenData.push_back(reqData1);
      seenCnt.push_back(cnt1);
      seenWe.push_back(we1);
      if (longint'(reqAddr1) + busN > 256) begin
        resCode1 <= `MEM_CODE_OUT_OF_BOUNDS;
        resData1 <= 32'hDEAD_BEEF;
      end else begin
        busRd = 32'h0;
        for (int k = 0; k < busN; k++) begin
          busRd[8*k +: 8] = busMem[int'(reqAddr1) + k];
          if (we1) busMem[int'(reqAddr1) + k] = reqData1[8*k +: 8];
        end
        resCode1 <= `MEM_CODE_OK;
        resData1 <= busRd;
      end
    end
  end

  always @(posedge clk) if (cnt0 != `MEM_COUNT_NONE) dut0Reqs++;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One access on the splitting unit, predicted byte by byte from refMem.
  task automatic applyStimulus(input logic st, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] wd);
    logic [31:0] eAddr [$];
    logic [31:0] eData [$];
    int          eSize [$];
    int          size, bSize, nBeats, lat, m;
    logic        legal, aligned, eFault;
    logic [31:0] val, eRd;
    longint      ba;
    size    = 1 << f3[1:0];
    legal   = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    aligned = (a % size) == 0;
    eFault  = 1'b0;
    val     = 32'h0;
    if (!legal) eFault = 1'b1;
    else begin
      nBeats = aligned ? 1 : size;
      bSize  = aligned ? size : 1;
      for (int k = 0; k < nBeats; k++) begin
        ba = longint'(a) + k;
        eAddr.push_back(32'(ba));
        eSize.push_back(bSize);
        eData.push_back(32'((longint'(wd) >> (8*k)) & ((longint'(1) << (8*bSize)) - 1)));
        if (ba + bSize > 256) begin
          eFault = 1'b1;
          break;
        end
        for (int j = 0; j < bSize; j++) begin
          if (st) refMem[int'(ba) + j] = wd[8*(k+j) +: 8];
          else    val[8*(k+j) +: 8] = refMem[int'(ba) + j];
        end
      end
    end
    eRd = 32'h0;
    if (!eFault && !st) begin
      case (f3)
        3'd0:    eRd = {{24{val[7]}}, val[7:0]};
        3'd1:    eRd = {{16{val[15]}}, val[15:0]};
        3'd4:    eRd = {24'h0, val[7:0]};
        3'd5:    eRd = {16'h0, val[15:0]};
        default: eRd = val;
      endcase
    end

    @(negedge clk);
    checkOutput("readyBefore", {31'h0, ready1}, 32'h1);
    isStore = st; funct3 = f3; addr = a; wrData = wd; valid1 = 1'b1;
    @(posedge clk);
    #1 valid1 = 1'b0;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (done1) begin
        lat = n;
        break;
      end
    end
    checkOutput("latency", 32'(lat), 32'(1 + 2*eAddr.size()));
    checkOutput("fault", {31'h0, fault1}, {31'h0, eFault});
    checkOutput("rdData", rd1, eRd);
    obsRd = rd1;
    obsFault = fault1;
    checkOutput("reqCount", 32'(seenAddr.size()), 32'(eAddr.size()));
    m = (seenAddr.size() < eAddr.size()) ? seenAddr.size() : eAddr.size();
    for (int k = 0; k < m; k++) begin
      checkOutput("reqAddr", seenAddr[k], eAddr[k]);
      checkOutput("reqSize", {30'h0, seenCnt[k]},
                  (eSize[k] == 1) ? 32'd1 : (eSize[k] == 2) ? 32'd2 : 32'd3);
      checkOutput("reqWe", {31'h0, seenWe[k]}, {31'h0, st});
      if (st) checkOutput("reqData", seenData[k], eData[k]);
    end
    seenAddr.delete(); seenData.delete(); seenCnt.delete(); seenWe.delete();
    @(negedge clk);
    checkOutput("readyAfter", {31'h0, ready1}, 32'h1);
  endtask

  // Directed access on the non-splitting unit, whose bus always returns 0xCAFE8001.
  task automatic runDut0(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input int expLat, input logic expFault, input logic [31:0] expRd,
                         input int expReqs);
    int lat;
    dut0Reqs = 0;
    @(negedge clk);
    isStore = st; funct3 = f3; addr = a; wrData = 32'h1234_5678; valid0 = 1'b1;
    @(posedge clk);
    #1 valid0 = 1'b0;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (done0) begin
        lat = n;
        break;
      end
    end
    checkOutput("d0Latency", 32'(lat), 32'(expLat));
    checkOutput("d0Fault", {31'h0, fault0}, {31'h0, expFault});
    checkOutput("d0RdData", rd0, expRd);
    checkOutput("d0Reqs", 32'(dut0Reqs), 32'(expReqs));
    @(negedge clk);
    checkOutput("d0Ready", {31'h0, ready0}, 32'h1);
  endtask

  task automatic resetMidAccess();
    logic sawDone;
    @(negedge clk);
    isStore = 1'b0; funct3 = 3'd2; addr = 32'h21; valid1 = 1'b1;
    @(posedge clk);
    #1 valid1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    aresetn = 1'b0;
    #1;
    checkOutput("rstReady", {31'h0, ready1}, 32'h1);
    checkOutput("rstDone", {31'h0, done1}, 32'h0);
    checkOutput("rstFault", {31'h0, fault1}, 32'h0);
    checkOutput("rstRd", rd1, 32'h0);
    checkOutput("rstCount", {30'h0, cnt1}, 32'h0);
    checkOutput("rstReqAddr", reqAddr1, 32'h0);
    @(negedge clk);
    aresetn = 1'b1;
    sawDone = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (done1) sawDone = 1'b1;
    end
    checkOutput("noDoneAfterRst", {31'h0, sawDone}, 32'h0);
    checkOutput("readyAfterRst", {31'h0, ready1}, 32'h1);
    seenAddr.delete(); seenData.delete(); seenCnt.delete(); seenWe.delete();
  endtask

  initial begin
    aresetn = 1'b0; valid1 = 1'b0; valid0 = 1'b0;
    isStore = 1'b0; funct3 = 3'd0; addr = 32'h0; wrData = 32'h0;
    resData1 = 32'h0; resCode1 = `MEM_CODE_OK;
    for (int i = 0; i < 256; i++) begin
      busMem[i] = 8'($urandom);
      refMem[i] = busMem[i];
    end
    busMem[16] = 8'h34; busMem[17] = 8'h12; busMem[18] = 8'hFF; busMem[19] = 8'h80;
    for (int i = 16; i < 20; i++) refMem[i] = busMem[i];

    #12;
    checkOutput("resetReady", {31'h0, ready1}, 32'h1);
    checkOutput("resetDone", {31'h0, done1}, 32'h0);
    checkOutput("resetFault", {31'h0, fault1}, 32'h0);
    checkOutput("resetRd", rd1, 32'h0);
    checkOutput("resetCount", {30'h0, cnt1}, 32'h0);
    checkOutput("resetWe", {31'h0, we1}, 32'h0);
    checkOutput("resetReqData", reqData1, 32'h0);
    @(negedge clk);
    aresetn = 1'b1;

    applyStimulus(1'b0, 3'd2, 32'h10, 32'h0);
    checkOutput("lw10", obsRd, 32'h80FF_1234);
    applyStimulus(1'b0, 3'd0, 32'h11, 32'h0);
    checkOutput("lb11", obsRd, 32'h0000_0012);
    applyStimulus(1'b0, 3'd0, 32'h13, 32'h0);
    checkOutput("lb13", obsRd, 32'hFFFF_FF80);
    applyStimulus(1'b0, 3'd4, 32'h13, 32'h0);
    checkOutput("lbu13", obsRd, 32'h0000_0080);
    applyStimulus(1'b1, 3'd2, 32'h21, 32'hAABB_CCDD);
    applyStimulus(1'b0, 3'd2, 32'h20, 32'h0);
    checkOutput("lw20Bytes", obsRd & 32'hFFFF_FF00, 32'hBBCC_DD00);
    applyStimulus(1'b0, 3'd2, 32'h24, 32'h0);
    checkOutput("lw24Byte", obsRd & 32'h0000_00FF, 32'h0000_00AA);
    applyStimulus(1'b0, 3'd1, 32'h03, 32'h0);
    applyStimulus(1'b0, 3'd2, 32'h100, 32'h0);
    checkOutput("oobFault", {31'h0, obsFault}, 32'h1);
    applyStimulus(1'b0, 3'd2, 32'hFE, 32'h0);
    checkOutput("splitOobFault", {31'h0, obsFault}, 32'h1);
    applyStimulus(1'b1, 3'd2, 32'hFD, 32'h1122_3344);
    applyStimulus(1'b0, 3'd3, 32'h10, 32'h0);
    applyStimulus(1'b1, 3'd4, 32'h10, 32'h0);

    runDut0(1'b0, 3'd1, 32'h03, 1, 1'b1, 32'h0, 0);
    runDut0(1'b0, 3'd1, 32'h02, 3, 1'b0, 32'hFFFF_8001, 1);
    runDut0(1'b1, 3'd2, 32'h21, 1, 1'b1, 32'h0, 0);
    runDut0(1'b0, 3'd4, 32'h03, 3, 1'b0, 32'h0000_0001, 1);

    resetMidAccess();

    for (int i = 0; i < 150; i++) begin
      logic [2:0] f3;
      f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      if (f3 == 3'd2 && $urandom_range(0, 2) == 0) f3 = 3'($urandom_range(4, 5));
      applyStimulus(1'($urandom_range(0, 1)), f3, 32'($urandom_range(0, 32'h10F)), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
